// File: rtl/udp_pkg.sv
// Shared constants, state encoding and header packing for the UDP header TX path.
// Wire order is big-endian; byte 0 of the packed header sits in bits [7:0].
package udp_pkg;

    localparam int          UDP_HDR_BYTES = 8;
    localparam logic [7:0]  IP_PROTO_UDP  = 8'h11;
    localparam logic [15:0] UDP_HDR_LEN   = 16'd8;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        SEND
    } udp_state_e;

    function automatic logic [63:0] udp_pack_hdr(
        input logic [15:0] ps,
        input logic [15:0] pd,
        input logic [15:0] len,
        input logic [15:0] csum
    );
        return {csum[7:0], csum[15:8],
                len[7:0],  len[15:8],
                pd[7:0],   pd[15:8],
                ps[7:0],   ps[15:8]};
    endfunction

endpackage

// File: rtl/udp_csum_fold.sv
// One's-complement accumulate over the UDP pseudo-header, then fold and invert.
// Used only when UDP_HEADER_TX_AXIS_CSUM_EN is defined.
module udp_csum_fold
    import udp_pkg::*;
(
    input  logic [31:0] ip_src,
    input  logic [31:0] ip_dst,
    input  logic [15:0] port_s,
    input  logic [15:0] port_d,
    input  logic [15:0] len,
    input  logic [15:0] csum_partial,
    input  logic [31:0] acc,
    output logic [31:0] sum,
    output logic [15:0] csum
);

    logic [16:0] fold1;
    logic [15:0] fold2;
    logic [15:0] inv;

    always_comb begin
        sum = 32'(ip_src[31:16]) + 32'(ip_src[15:0])
            + 32'(ip_dst[31:16]) + 32'(ip_dst[15:0])
            + 32'({8'h00, IP_PROTO_UDP}) + 32'(len)
            + 32'(port_s) + 32'(port_d)
            + 32'(len) + 32'(csum_partial);
    end

    // Two folds always land in 16 bits: first fold tops out at 17'h1FFFE.
    always_comb begin
        fold1 = {1'b0, acc[15:0]} + {1'b0, acc[31:16]};
        fold2 = fold1[15:0] + {15'h0, fold1[16]};
        inv   = ~fold2;
        csum  = (inv == 16'h0000) ? 16'hFFFF : inv;
    end

endmodule

// File: rtl/udp_header_tx_axis.sv
// UDP header generator streaming the 8-byte header as an AXI-Stream master.
// Define UDP_HEADER_TX_AXIS_CSUM_EN to compute the checksum field.
module udp_header_tx_axis
    import udp_pkg::*;
#(
    parameter int DATA_BYTES  = 1,
    parameter bit ADD_HDR_LEN = 1'b1
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    start,
    input  logic [15:0]             port_s,
    input  logic [15:0]             port_d,
    input  logic [15:0]             udp_len,
    input  logic [31:0]             ip_src,
    input  logic [31:0]             ip_dst,
    input  logic [15:0]             csum_partial,
    output logic [8*DATA_BYTES-1:0] m_tdata,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic                    m_tlast,
    output logic                    busy,
    output logic                    hdr_done
);

    localparam int         W     = 8 * DATA_BYTES;
    localparam int         BEATS = UDP_HDR_BYTES / DATA_BYTES;
    localparam logic [2:0] LAST  = 3'(BEATS - 1);

    generate
        if (!(DATA_BYTES == 1 || DATA_BYTES == 2 ||
              DATA_BYTES == 4 || DATA_BYTES == 8)) begin : g_bad_width
            $error("udp_header_tx_axis: DATA_BYTES must be 1, 2, 4 or 8");
        end
    endgenerate

    udp_state_e  state;
    logic [63:0] hdr;
    logic [2:0]  cnt;
    logic [15:0] len_in;

    assign len_in = ADD_HDR_LEN ? (udp_len + UDP_HDR_LEN) : udp_len;

    function automatic logic [W-1:0] beat(
        input logic [63:0] h,
        input logic [2:0]  k
    );
        return h[int'(k) * W +: W];
    endfunction

`ifdef UDP_HEADER_TX_AXIS_CSUM_EN
    logic [31:0] ip_src_q;
    logic [31:0] ip_dst_q;
    logic [15:0] part_q;
    logic [31:0] acc;
    logic [31:0] sum;
    logic [15:0] csum;
    logic        phase;

    udp_csum_fold u_fold (
        .ip_src       (ip_src_q),
        .ip_dst       (ip_dst_q),
        .port_s       ({hdr[7:0], hdr[15:8]}),
        .port_d       ({hdr[23:16], hdr[31:24]}),
        .len          ({hdr[39:32], hdr[47:40]}),
        .csum_partial (part_q),
        .acc          (acc),
        .sum          (sum),
        .csum         (csum)
    );
`else
    logic unused_csum_inputs;
    assign unused_csum_inputs = ^{ip_src, ip_dst, csum_partial};
`endif

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state    <= IDLE;
            hdr      <= '0;
            cnt      <= '0;
            m_tdata  <= '0;
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            busy     <= 1'b0;
            hdr_done <= 1'b0;
`ifdef UDP_HEADER_TX_AXIS_CSUM_EN
            ip_src_q <= '0;
            ip_dst_q <= '0;
            part_q   <= '0;
            acc      <= '0;
            phase    <= 1'b0;
`endif
        end else begin
            hdr_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        cnt  <= '0;
                        hdr  <= udp_pack_hdr(port_s, port_d, len_in, 16'h0000);
`ifdef UDP_HEADER_TX_AXIS_CSUM_EN
                        ip_src_q <= ip_src;
                        ip_dst_q <= ip_dst;
                        part_q   <= csum_partial;
                        phase    <= 1'b0;
                        state    <= CALC;
`else
                        m_tvalid <= 1'b1;
                        m_tlast  <= (LAST == 3'd0);
                        m_tdata  <= beat(udp_pack_hdr(port_s, port_d, len_in, 16'h0000), 3'd0);
                        state    <= SEND;
`endif
                    end
                end
                CALC: begin
`ifdef UDP_HEADER_TX_AXIS_CSUM_EN
                    if (!phase) begin
                        acc   <= sum;
                        phase <= 1'b1;
                    end else begin
                        hdr[63:48] <= {csum[7:0], csum[15:8]};
                        m_tvalid   <= 1'b1;
                        m_tlast    <= (LAST == 3'd0);
                        m_tdata    <= beat({csum[7:0], csum[15:8], hdr[47:0]}, 3'd0);
                        state      <= SEND;
                    end
`else
                    state <= IDLE;
`endif
                end
                SEND: begin
                    if (m_tvalid && m_tready) begin
                        if (cnt == LAST) begin
                            m_tvalid <= 1'b0;
                            m_tlast  <= 1'b0;
                            m_tdata  <= '0;
                            busy     <= 1'b0;
                            hdr_done <= 1'b1;
                            cnt      <= '0;
                            state    <= IDLE;
                        end else begin
                            cnt     <= cnt + 3'd1;
                            m_tdata <= beat(hdr, cnt + 3'd1);
                            m_tlast <= ((cnt + 3'd1) == LAST);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_udp_header_tx_axis.sv
// Randomized bench for udp_header_tx_axis: three widths against a byte-stream model.
// Follows UDP_HEADER_TX_AXIS_CSUM_EN for checksum and latency expectations.
module tb_udp_header_tx_axis;

`ifdef UDP_HEADER_TX_AXIS_CSUM_EN
    localparam bit CSUM = 1'b1;
    localparam int LAT  = 3;
`else
    localparam bit CSUM = 1'b0;
    localparam int LAT  = 1;
`endif

    logic        aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic        aresetn = 1'b0;
    logic        start = 1'b0;
    logic [15:0] port_s = '0;
    logic [15:0] port_d = '0;
    logic [15:0] udp_len = '0;
    logic [15:0] csum_partial = '0;
    logic [31:0] ip_src = '0;
    logic [31:0] ip_dst = '0;
    logic [7:0]  td0;
    logic [31:0] td1;
    logic [63:0] td2;
    logic [2:0]  tv, tl, bz, hd;
    logic [2:0]  tr = 3'b111;

    int total = 0;
    int bad = 0;

    udp_header_tx_axis #(.DATA_BYTES(1), .ADD_HDR_LEN(1'b1)) u0 (
        .aclk(aclk), .aresetn(aresetn), .start(start),
        .port_s(port_s), .port_d(port_d), .udp_len(udp_len),
        .ip_src(ip_src), .ip_dst(ip_dst), .csum_partial(csum_partial),
        .m_tdata(td0), .m_tvalid(tv[0]), .m_tready(tr[0]), .m_tlast(tl[0]),
        .busy(bz[0]), .hdr_done(hd[0])
    );

    udp_header_tx_axis #(.DATA_BYTES(4), .ADD_HDR_LEN(1'b1)) u1 (
        .aclk(aclk), .aresetn(aresetn), .start(start),
        .port_s(port_s), .port_d(port_d), .udp_len(udp_len),
        .ip_src(ip_src), .ip_dst(ip_dst), .csum_partial(csum_partial),
        .m_tdata(td1), .m_tvalid(tv[1]), .m_tready(tr[1]), .m_tlast(tl[1]),
        .busy(bz[1]), .hdr_done(hd[1])
    );

    udp_header_tx_axis #(.DATA_BYTES(8), .ADD_HDR_LEN(1'b0)) u2 (
        .aclk(aclk), .aresetn(aresetn), .start(start),
        .port_s(port_s), .port_d(port_d), .udp_len(udp_len),
        .ip_src(ip_src), .ip_dst(ip_dst), .csum_partial(csum_partial),
        .m_tdata(td2), .m_tvalid(tv[2]), .m_tready(tr[2]), .m_tlast(tl[2]),
        .busy(bz[2]), .hdr_done(hd[2])
    );

    function automatic int nb(input int d);
        return (d == 0) ? 1 : (d == 1) ? 4 : 8;
    endfunction

    function automatic bit addl(input int d);
        return d != 2;
    endfunction

    function logic [63:0] tdx(input int d);
        return (d == 0) ? 64'(td0) : (d == 1) ? 64'(td1) : td2;
    endfunction

    // Header as it appears on the wire, first byte in [63:56].
    function automatic logic [63:0] model(
        input logic [15:0] ps, input logic [15:0] pd,
        input logic [15:0] ln, input logic [15:0] pp,
        input logic [31:0] sa, input logic [31:0] da,
        input bit add
    );
        logic [15:0] len_f;
        logic [15:0] cs;
        int unsigned acc;
        int unsigned w [10];
        len_f = add ? 16'(ln + 16'd8) : ln;
        w = '{32'(sa[31:16]), 32'(sa[15:0]), 32'(da[31:16]), 32'(da[15:0]),
              32'h11, 32'(len_f), 32'(ps), 32'(pd), 32'(len_f), 32'(pp)};
        acc = 0;
        foreach (w[k]) acc += w[k];
        while (acc > 32'hFFFF) acc = (acc & 32'hFFFF) + (acc >> 16);
        cs = ~acc[15:0];
        if (cs == 16'h0000) cs = 16'hFFFF;
        return {ps, pd, len_f, CSUM ? cs : 16'h0000};
    endfunction

    logic [7:0] got   [3][64];
    logic       lastf [3][64];
    int         ngot [3];
    int         nbt  [3];
    int         fv   [3];
    int         dn   [3];
    int         dc   [3];
    logic       bzv  [3];
    logic       bzd  [3];

    task automatic scramble();
        port_s       = 16'($urandom);
        port_d       = 16'($urandom);
        udp_len      = 16'($urandom);
        csum_partial = 16'($urandom);
        ip_src       = $urandom;
        ip_dst       = $urandom;
    endtask

    task automatic run_hdr(
        input logic [15:0] ps, input logic [15:0] pd,
        input logic [15:0] ln, input logic [15:0] pp,
        input logic [31:0] sa, input logic [31:0] da,
        input bit rnd, input bit glitch
    );
        logic [63:0] t;
        int mx;
        for (int d = 0; d < 3; d++) begin
            ngot[d] = 0; nbt[d] = 0; fv[d] = -1;
            dn[d] = 0; dc[d] = -1; bzv[d] = 1'b0; bzd[d] = 1'b1;
        end
        for (int i = 0; i < 150; i++) begin
            @(posedge aclk); #1;
            start = (i == 0) || (glitch && i == 1);
            if (i == 0) begin
                port_s = ps; port_d = pd; udp_len = ln;
                csum_partial = pp; ip_src = sa; ip_dst = da;
            end else begin
                scramble();
            end
            tr = rnd ? 3'($urandom) : 3'b111;
            @(negedge aclk);
            for (int d = 0; d < 3; d++) begin
                t = tdx(d);
                if (tv[d] && fv[d] < 0) begin
                    fv[d] = i;
                    bzv[d] = bz[d];
                end
                if (tv[d] && tr[d] && nbt[d] < 64) begin
                    for (int b = 0; b < nb(d); b++) begin
                        if (ngot[d] < 64) begin
                            got[d][ngot[d]] = t[8*b +: 8];
                            ngot[d]++;
                        end
                    end
                    lastf[d][nbt[d]] = tl[d];
                    nbt[d]++;
                end
                if (hd[d]) begin
                    dn[d]++;
                    if (dc[d] < 0) begin
                        dc[d] = i;
                        bzd[d] = bz[d];
                    end
                end
            end
            mx = (dc[0] > dc[1]) ? dc[0] : dc[1];
            mx = (mx > dc[2]) ? mx : dc[2];
            if (dn[0] > 0 && dn[1] > 0 && dn[2] > 0 && i >= mx + 3) break;
        end
        start = 1'b0;
        tr = 3'b111;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        total++;
        if (tv !== 3'b000) begin bad++; $display("FAIL reset_tvalid got=%b want=000", tv); end
        total++;
        if (tl !== 3'b000) begin bad++; $display("FAIL reset_tlast got=%b want=000", tl); end
        total++;
        if (bz !== 3'b000) begin bad++; $display("FAIL reset_busy got=%b want=000", bz); end
        total++;
        if (hd !== 3'b000) begin bad++; $display("FAIL reset_hdr_done got=%b want=000", hd); end
        total++;
        if ({td0, td1, td2} !== 104'h0) begin
            bad++;
            $display("FAIL reset_tdata got=%h/%h/%h want=0", td0, td1, td2);
        end
        @(posedge aclk); #1;
        aresetn = 1'b1;
    endtask

    task automatic test_directed();
        logic [63:0] g;
        logic [63:0] e;
        bit ok;
        run_hdr(16'h1234, 16'h5678, 16'h0010, 16'h0000,
                32'hC0A80001, 32'hC0A80002, 1'b0, 1'b0);
        for (int d = 0; d < 3; d++) begin
            g = '0;
            for (int j = 0; j < 8; j++) g[63-8*j -: 8] = got[d][j];
            if (d == 2) e = {48'h1234_5678_0010, CSUM ? 16'h15CE : 16'h0000};
            else        e = {48'h1234_5678_0018, CSUM ? 16'h15BE : 16'h0000};
            total++;
            if (ngot[d] !== 8 || g !== e) begin
                bad++;
                $display("FAIL dir_bytes dut%0d got=%h n=%0d want=%h", d, g, ngot[d], e);
            end
            total++;
            if (fv[d] !== LAT || bzv[d] !== 1'b1) begin
                bad++;
                $display("FAIL dir_latency dut%0d got=%0d busy=%b want=%0d", d, fv[d], bzv[d], LAT);
            end
            total++;
            if (dn[d] !== 1 || dc[d] !== LAT + 8 / nb(d) || bzd[d] !== 1'b0) begin
                bad++;
                $display("FAIL dir_done dut%0d got=%0d@%0d busy=%b want=1@%0d",
                         d, dn[d], dc[d], bzd[d], LAT + 8 / nb(d));
            end
            ok = (nbt[d] == 8 / nb(d));
            for (int j = 0; j < nbt[d] && j < 64; j++)
                if (lastf[d][j] !== (j == nbt[d] - 1)) ok = 0;
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL dir_tlast dut%0d got_beats=%0d want=%0d", d, nbt[d], 8 / nb(d));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] b1;
        int seen;
        b1 = CSUM ? 32'hBE151800 : 32'h00001800;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge aclk); #1;
            start = (i == 0);
            if (i == 0) begin
                port_s = 16'h1234; port_d = 16'h5678; udp_len = 16'h0010;
                csum_partial = 16'h0; ip_src = 32'hC0A80001; ip_dst = 32'hC0A80002;
            end else begin
                scramble();
            end
            tr = {1'b1, !(i >= LAT && i < LAT + 3), 1'b1};
            @(negedge aclk);
            if (i >= LAT && i <= LAT + 3) begin
                total++;
                if (tv[1] !== 1'b1 || tl[1] !== 1'b0 || td1 !== 32'h78563412) begin
                    bad++;
                    $display("FAIL bp_hold cycle=%0d got=%h v=%b want=78563412", i, td1, tv[1]);
                end
            end
            if (i == LAT + 4) begin
                total++;
                if (tv[1] !== 1'b1 || tl[1] !== 1'b1 || td1 !== b1) begin
                    bad++;
                    $display("FAIL bp_beat1 got=%h last=%b want=%h", td1, tl[1], b1);
                end
            end
            if (hd[1]) seen++;
        end
        start = 1'b0;
        total++;
        if (seen !== 1) begin bad++; $display("FAIL bp_done got=%0d want=1", seen); end
    endtask

    task automatic test_ignore_start();
        logic [15:0] ps, pd, ln, pp;
        logic [31:0] sa, da;
        logic [63:0] g;
        logic [63:0] e;
        for (int r = 0; r < 2; r++) begin
            ps = 16'($urandom); pd = 16'($urandom); ln = 16'($urandom);
            pp = 16'($urandom); sa = $urandom; da = $urandom;
            run_hdr(ps, pd, ln, pp, sa, da, 1'b1, r == 0);
            for (int d = 0; d < 3; d++) begin
                g = '0;
                for (int j = 0; j < 8; j++) g[63-8*j -: 8] = got[d][j];
                e = model(ps, pd, ln, pp, sa, da, addl(d));
                total++;
                if (ngot[d] !== 8 || g !== e || dn[d] !== 1) begin
                    bad++;
                    $display("FAIL ignore_start r%0d dut%0d got=%h n=%0d done=%0d want=%h",
                             r, d, g, ngot[d], dn[d], e);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ps, pd, ln, pp;
        logic [31:0] sa, da;
        logic [7:0]  bytes [16];
        logic [63:0] ga, gb, ea, eb;
        int n, pulses, d1, d2;
        ps = 16'($urandom); pd = 16'($urandom); ln = 16'($urandom);
        pp = 16'($urandom); sa = $urandom; da = $urandom;
        n = 0; pulses = 0; d1 = -1; d2 = -1;
        for (int i = 0; i < 60; i++) begin
            @(posedge aclk); #1;
            start = (i == 0) || (i == LAT + 8);
            if (i == 0) begin
                port_s = 16'h1234; port_d = 16'h5678; udp_len = 16'h0010;
                csum_partial = 16'h0; ip_src = 32'hC0A80001; ip_dst = 32'hC0A80002;
            end else if (i == LAT + 8) begin
                port_s = ps; port_d = pd; udp_len = ln;
                csum_partial = pp; ip_src = sa; ip_dst = da;
            end else begin
                scramble();
            end
            tr = 3'b111;
            @(negedge aclk);
            if (tv[0]) begin
                if (n < 16) bytes[n] = td0;
                n++;
            end
            if (hd[0]) begin
                pulses++;
                if (pulses == 1) d1 = i;
                if (pulses == 2) d2 = i;
            end
        end
        start = 1'b0;
        ga = '0; gb = '0;
        for (int j = 0; j < 8; j++) begin
            ga[63-8*j -: 8] = bytes[j];
            gb[63-8*j -: 8] = bytes[j+8];
        end
        ea = model(16'h1234, 16'h5678, 16'h0010, 16'h0, 32'hC0A80001, 32'hC0A80002, 1'b1);
        eb = model(ps, pd, ln, pp, sa, da, 1'b1);
        total++;
        if (n !== 16 || ga !== ea || gb !== eb) begin
            bad++;
            $display("FAIL b2b_bytes n=%0d got=%h %h want=%h %h", n, ga, gb, ea, eb);
        end
        total++;
        if (pulses !== 2 || d1 !== LAT + 8 || d2 !== 2 * (LAT + 8)) begin
            bad++;
            $display("FAIL b2b_done got=%0d@%0d,%0d want=2@%0d,%0d",
                     pulses, d1, d2, LAT + 8, 2 * (LAT + 8));
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] ps, pd, ln, pp;
        logic [31:0] sa, da;
        logic [63:0] g;
        logic [63:0] e;
        int pulses;
        pulses = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge aclk); #1;
            start = (i == 0);
            scramble();
            tr = 3'b111;
            if (i == LAT + 3) aresetn = 1'b0;
            if (i == LAT + 4) aresetn = 1'b1;
            @(negedge aclk);
            if (i == LAT + 3) begin
                total++;
                if (tv[0] !== 1'b1 || bz[0] !== 1'b1) begin
                    bad++;
                    $display("FAIL rstmid_active got=%b/%b want=1/1", tv[0], bz[0]);
                end
            end
            if (i == LAT + 4) begin
                total++;
                if (tv !== 3'b000 || bz !== 3'b000 || tl !== 3'b000 || td0 !== 8'h00) begin
                    bad++;
                    $display("FAIL rstmid_abort got=v%b b%b l%b d%h want=0", tv, bz, tl, td0);
                end
            end
            if (i >= LAT + 4 && hd !== 3'b000) pulses++;
        end
        start = 1'b0;
        total++;
        if (pulses !== 0) begin bad++; $display("FAIL rstmid_done got=%0d want=0", pulses); end
        ps = 16'($urandom); pd = 16'($urandom); ln = 16'($urandom);
        pp = 16'($urandom); sa = $urandom; da = $urandom;
        run_hdr(ps, pd, ln, pp, sa, da, 1'b1, 1'b0);
        g = '0;
        for (int j = 0; j < 8; j++) g[63-8*j -: 8] = got[0][j];
        e = model(ps, pd, ln, pp, sa, da, 1'b1);
        total++;
        if (ngot[0] !== 8 || g !== e || dn[0] !== 1) begin
            bad++;
            $display("FAIL rstmid_fresh got=%h n=%0d done=%0d want=%h", g, ngot[0], dn[0], e);
        end
    endtask

    task automatic test_random();
        logic [15:0] ps, pd, ln, pp;
        logic [31:0] sa, da;
        logic [63:0] g;
        logic [63:0] e;
        bit ok;
        for (int n = 0; n < 24; n++) begin
            if (n == 0) begin
                ps = 16'h0; pd = 16'h0; ln = 16'hFFF8; pp = 16'hFFEE; sa = 32'h0; da = 32'h0;
            end else begin
                ps = 16'($urandom); pd = 16'($urandom); ln = 16'($urandom);
                pp = 16'($urandom); sa = $urandom; da = $urandom;
            end
            run_hdr(ps, pd, ln, pp, sa, da, 1'b1, n[0]);
            for (int d = 0; d < 3; d++) begin
                g = '0;
                for (int j = 0; j < 8; j++) g[63-8*j -: 8] = got[d][j];
                e = model(ps, pd, ln, pp, sa, da, addl(d));
                total++;
                if (ngot[d] !== 8 || g !== e) begin
                    bad++;
                    $display("FAIL rand_bytes #%0d dut%0d got=%h n=%0d want=%h", n, d, g, ngot[d], e);
                end
                ok = (nbt[d] == 8 / nb(d)) && (dn[d] == 1) && (bzd[d] == 1'b0);
                for (int j = 0; j < nbt[d] && j < 64; j++)
                    if (lastf[d][j] !== (j == nbt[d] - 1)) ok = 0;
                total++;
                if (!ok) begin
                    bad++;
                    $display("FAIL rand_framing #%0d dut%0d beats=%0d done=%0d want=%0d/1",
                             n, d, nbt[d], dn[d], 8 / nb(d));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
